// File: rtl/axi_mem_responder.sv
//------------------------------------------------------------------------------
// Module   : axi_mem_responder
// Function : AXI4 slave over a word-organised RAM; concurrent R/W FSMs with
//            single-beat and INCR/FIXED bursts. Optional AXI_MEM_DECERR_EN
//            enables address range checking with DECERR responses.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ravenoc_pkg;
  localparam int AXI_ID_WIDTH = 8;

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0] awid;
    logic [31:0]             awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic [31:0]             wdata;
    logic [3:0]              wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    bready;
    logic [AXI_ID_WIDTH-1:0] arid;
    logic [31:0]             araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic                    awready;
    logic                    wready;
    logic [AXI_ID_WIDTH-1:0] bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    arready;
    logic [AXI_ID_WIDTH-1:0] rid;
    logic [31:0]             rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
  } s_axi_miso_t;
endpackage

module axi_mem_responder
  import ravenoc_pkg::*;
#(
  parameter int          MEM_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter              INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        arst,
  input  s_axi_mosi_t axi_mosi,
  output s_axi_miso_t axi_miso
);

  localparam int       IDX_W  = $clog2(MEM_WORDS);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_FETCH = 2'd1, R_DATA = 2'd2} rstate_e;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_e;

  logic [31:0] mem [MEM_WORDS];

  rstate_e                 rstate_q;
  logic                    arready_q, rvalid_q, rlast_q;
  logic [31:0]             rdata_q, raddr_q, raddr_d;
  logic [1:0]              rresp_q, rburst_q;
  logic [7:0]              rlen_q, rbeat_q;
  logic [AXI_ID_WIDTH-1:0] rid_q, rid_lat_q;

  wstate_e                 wstate_q;
  logic                    awready_q, wready_q, bvalid_q, werr_q, wdec_q, werr_d, wdec_d;
  logic [31:0]             waddr_q, waddr_d;
  logic [1:0]              bresp_q, wburst_q;
  logic [7:0]              wlen_q, wbeat_q;
  logic [AXI_ID_WIDTH-1:0] bid_q, wid_lat_q;

  // 33-bit offsets so an address below BASE_ADDR shows up as a huge value
  logic [32:0]      rd_off, wr_off;
  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic             rd_dec, wr_dec, wr_en, wr_last;
  logic             unused_ok;

  assign rd_off  = {1'b0, raddr_q} - {1'b0, BASE_ADDR};
  assign wr_off  = {1'b0, waddr_q} - {1'b0, BASE_ADDR};
  assign rd_idx  = rd_off[IDX_W+1:2];
  assign wr_idx  = wr_off[IDX_W+1:2];
  assign raddr_d = (rburst_q == 2'b00) ? raddr_q : raddr_q + 32'd4;
  assign waddr_d = (wburst_q == 2'b00) ? waddr_q : waddr_q + 32'd4;

`ifdef AXI_MEM_DECERR_EN
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;
  assign rd_dec = (rd_off >= MEM_BYTES);
  assign wr_dec = (wr_off >= MEM_BYTES);
`else
  assign rd_dec = 1'b0;
  assign wr_dec = 1'b0;
`endif

  assign wr_last = (wbeat_q == wlen_q);
  assign werr_d  = werr_q | (axi_mosi.wlast != wr_last);
  assign wdec_d  = wdec_q | wr_dec;
  assign wr_en   = !arst && (wstate_q == W_DATA) && axi_mosi.wvalid && wready_q && !wr_dec;

  assign unused_ok = ^{axi_mosi.awsize, axi_mosi.arsize, rd_off, wr_off};

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (axi_mosi.wstrb[b]) mem[wr_idx][8*b +: 8] <= axi_mosi.wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
      rid_q     <= '0;
      rid_lat_q <= '0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rbeat_q   <= '0;
      rburst_q  <= '0;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          if (axi_mosi.arvalid && arready_q) begin
            raddr_q   <= axi_mosi.araddr;
            rlen_q    <= axi_mosi.arlen;
            rid_lat_q <= axi_mosi.arid;
            rburst_q  <= axi_mosi.arburst;
            rbeat_q   <= '0;
            arready_q <= 1'b0;
            rstate_q  <= R_FETCH;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_FETCH: begin
          rdata_q  <= rd_dec ? 32'd0 : mem[rd_idx];
          rresp_q  <= rd_dec ? DECERR : OKAY;
          rlast_q  <= (rbeat_q == rlen_q);
          rid_q    <= rid_lat_q;
          rvalid_q <= 1'b1;
          rstate_q <= R_DATA;
        end
        R_DATA: begin
          if (axi_mosi.rready) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            if (rlast_q) begin
              rstate_q <= R_IDLE;
            end else begin
              rbeat_q  <= rbeat_q + 8'd1;
              raddr_q  <= raddr_d;
              rstate_q <= R_FETCH;
            end
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      bid_q     <= '0;
      wid_lat_q <= '0;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wbeat_q   <= '0;
      wburst_q  <= '0;
      werr_q    <= 1'b0;
      wdec_q    <= 1'b0;
    end else begin
      case (wstate_q)
        W_IDLE: begin
          if (axi_mosi.awvalid && awready_q) begin
            waddr_q   <= axi_mosi.awaddr;
            wlen_q    <= axi_mosi.awlen;
            wid_lat_q <= axi_mosi.awid;
            wburst_q  <= axi_mosi.awburst;
            wbeat_q   <= '0;
            werr_q    <= 1'b0;
            wdec_q    <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            wstate_q  <= W_DATA;
          end else begin
            awready_q <= 1'b1;
          end
        end
        W_DATA: begin
          if (axi_mosi.wvalid && wready_q) begin
            werr_q <= werr_d;
            wdec_q <= wdec_d;
            if (wr_last) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bid_q    <= wid_lat_q;
              bresp_q  <= wdec_d ? DECERR : (werr_d ? SLVERR : OKAY);
              wstate_q <= W_RESP;
            end else begin
              wbeat_q <= wbeat_q + 8'd1;
              waddr_q <= waddr_d;
            end
          end
        end
        W_RESP: begin
          if (axi_mosi.bready) begin
            bvalid_q <= 1'b0;
            wstate_q <= W_IDLE;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  always_comb begin
    axi_miso         = '0;
    axi_miso.awready = awready_q;
    axi_miso.wready  = wready_q;
    axi_miso.bid     = bid_q;
    axi_miso.bresp   = bresp_q;
    axi_miso.bvalid  = bvalid_q;
    axi_miso.arready = arready_q;
    axi_miso.rid     = rid_q;
    axi_miso.rdata   = rdata_q;
    axi_miso.rresp   = rresp_q;
    axi_miso.rlast   = rlast_q;
    axi_miso.rvalid  = rvalid_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_mem_responder.sv
//------------------------------------------------------------------------------
// Module   : tb_axi_mem_responder
// Function : Self-checking bench for axi_mem_responder (MEM_WORDS=16).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_axi_mem_responder;
  import ravenoc_pkg::*;

  localparam int MW = 16;
`ifdef AXI_MEM_DECERR_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  s_axi_mosi_t mosi;
  s_axi_miso_t miso;

  always #5 clk = ~clk;

  axi_mem_responder #(
    .MEM_WORDS(MW),
    .BASE_ADDR(32'h0000_0000),
    .INIT_FILE("")
  ) dut (
    .clk      (clk),
    .arst     (arst),
    .axi_mosi (mosi),
    .axi_miso (miso)
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  wid;
    logic [7:0]  rid;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[7];
  logic [31:0] wbuf[8];
  logic [31:0] rexp[8];
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timeout waiting for handshake", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input string tag, input logic [31:0] addr, input logic [7:0] id,
                           input logic [7:0] len, input logic [1:0] burst, input logic [3:0] strb,
                           input bit early_wlast, input logic [1:0] exp_bresp);
    int g;
    mosi.awaddr  = addr;
    mosi.awid    = id;
    mosi.awlen   = len;
    mosi.awburst = burst;
    mosi.awsize  = 3'd2;
    mosi.awvalid = 1'b1;
    g = 0;
    while (!miso.awready && g < 50) begin step(); g++; end
    if (g == 50) tmo({tag, "_aw"});
    step();
    mosi.awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      mosi.wdata  = wbuf[b];
      mosi.wstrb  = strb;
      mosi.wlast  = (b == int'(len)) || (early_wlast && b == 0);
      mosi.wvalid = 1'b1;
      g = 0;
      while (!miso.wready && g < 50) begin step(); g++; end
      if (g == 50) tmo({tag, "_w"});
      step();
    end
    mosi.wvalid = 1'b0;
    mosi.wlast  = 1'b0;
    mosi.bready = 1'b1;
    g = 0;
    while (!miso.bvalid && g < 50) begin step(); g++; end
    if (g == 50) tmo({tag, "_b"});
    chk({tag, "_bid"}, 64'(miso.bid), 64'(id));
    chk({tag, "_bresp"}, 64'(miso.bresp), 64'(exp_bresp));
    step();
    mosi.bready = 1'b0;
    chk({tag, "_bvalid_clr"}, 64'(miso.bvalid), 64'd0);
  endtask

  task automatic axi_read(input string tag, input logic [31:0] addr, input logic [7:0] id,
                          input logic [7:0] len, input logic [1:0] burst, input bit toggle,
                          input logic [1:0] exp_rresp);
    int g;
    int beat;
    bit phase;
    mosi.araddr  = addr;
    mosi.arid    = id;
    mosi.arlen   = len;
    mosi.arburst = burst;
    mosi.arsize  = 3'd2;
    mosi.arvalid = 1'b1;
    g = 0;
    while (!miso.arready && g < 50) begin step(); g++; end
    if (g == 50) tmo({tag, "_ar"});
    step();
    mosi.arvalid = 1'b0;
    // first rvalid appears two cycles after the AR handshake cycle
    chk({tag, "_lat_n1"}, 64'(miso.rvalid), 64'd0);
    step();
    chk({tag, "_lat_n2"}, 64'(miso.rvalid), 64'd1);
    beat  = 0;
    phase = 1'b1;
    g     = 0;
    while (beat <= int'(len) && g < 200) begin
      mosi.rready = toggle ? phase : 1'b1;
      if (miso.rvalid) begin
        chk($sformatf("%s_rdata%0d", tag, beat), 64'(miso.rdata), 64'(rexp[beat]));
        chk($sformatf("%s_rid%0d", tag, beat), 64'(miso.rid), 64'(id));
        chk($sformatf("%s_rresp%0d", tag, beat), 64'(miso.rresp), 64'(exp_rresp));
        chk($sformatf("%s_rlast%0d", tag, beat), 64'(miso.rlast), 64'(beat == int'(len)));
        if (mosi.rready) beat++;
      end
      step();
      phase = ~phase;
      g++;
    end
    if (g == 200) tmo({tag, "_r"});
    mosi.rready = 1'b0;
    chk({tag, "_rvalid_clr"}, 64'(miso.rvalid), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int cnt;
    vecs[0] = '{32'h10, 8'd3,  8'd5,   32'hDEADBEEF, 4'hF,    32'hDEADBEEF};
    vecs[1] = '{32'h10, 8'd1,  8'd2,   32'h11223344, 4'b0101, 32'hDE22BE44};
    vecs[2] = '{32'h14, 8'd7,  8'd8,   32'hA5A5A5A5, 4'hF,    32'hA5A5A5A5};
    vecs[3] = '{32'h14, 8'd9,  8'd10,  32'h0000FFFF, 4'b1100, 32'h0000A5A5};
    vecs[4] = '{32'h13, 8'd4,  8'd6,   32'h99887766, 4'b1000, 32'h9922BE44};
    vecs[5] = '{32'h3C, 8'd15, 8'd14,  32'h12345678, 4'hF,    32'h12345678};
    vecs[6] = '{32'h3C, 8'd0,  8'd255, 32'hFFFFFFFF, 4'h0,    32'h12345678};

    mosi = '0;
    arst = 1'b1;
    step();
    step();
    chk("reset_miso", 64'(miso), 64'd0);
    arst = 1'b0;
    step();
    chk("idle_arready", 64'(miso.arready), 64'd1);
    chk("idle_awready", 64'(miso.awready), 64'd1);

    // W beat with no AW must not be accepted
    mosi.wvalid = 1'b1;
    mosi.wdata  = 32'hBAD0BAD0;
    mosi.wstrb  = 4'hF;
    mosi.wlast  = 1'b1;
    step();
    chk("w_before_aw_wready", 64'(miso.wready), 64'd0);
    step();
    chk("w_before_aw_wready2", 64'(miso.wready), 64'd0);
    mosi.wvalid = 1'b0;
    mosi.wlast  = 1'b0;

    for (int i = 0; i < 7; i++) begin
      wbuf[0] = vecs[i].wdata;
      rexp[0] = vecs[i].exp;
      axi_write($sformatf("vec%0d_wr", i), vecs[i].addr, vecs[i].wid, 8'd0, 2'b01,
                vecs[i].strb, 1'b0, 2'b00);
      axi_read($sformatf("vec%0d_rd", i), vecs[i].addr, vecs[i].rid, 8'd0, 2'b01, 1'b0, 2'b00);
    end

    wbuf[0] = 32'd1; wbuf[1] = 32'd2; wbuf[2] = 32'd3; wbuf[3] = 32'd4;
    axi_write("wburst", 32'h0, 8'd2, 8'd3, 2'b01, 4'hF, 1'b0, 2'b00);
    rexp[0] = 32'd1; rexp[1] = 32'd2; rexp[2] = 32'd3; rexp[3] = 32'd4;
    axi_read("rburst", 32'h0, 8'd6, 8'd3, 2'b01, 1'b1, 2'b00);

    wbuf[0] = 32'hAAAA0001; wbuf[1] = 32'hAAAA0002;
    axi_write("wlast_err", 32'h20, 8'd11, 8'd1, 2'b01, 4'hF, 1'b1, 2'b10);
    rexp[0] = 32'hAAAA0001; rexp[1] = 32'hAAAA0002;
    axi_read("wlast_err_rd", 32'h20, 8'd12, 8'd1, 2'b01, 1'b0, 2'b00);

    wbuf[0] = 32'h11; wbuf[1] = 32'h22;
    axi_write("fixed_wr", 32'h30, 8'd16, 8'd1, 2'b00, 4'hF, 1'b0, 2'b00);
    rexp[0] = 32'h22; rexp[1] = 32'h22;
    axi_read("fixed_rd", 32'h30, 8'd17, 8'd1, 2'b00, 1'b1, 2'b00);

    // reset during beat 2 of an 8-beat read
    mosi.araddr  = 32'h0;
    mosi.arid    = 8'd20;
    mosi.arlen   = 8'd7;
    mosi.arburst = 2'b01;
    mosi.arvalid = 1'b1;
    g = 0;
    while (!miso.arready && g < 50) begin step(); g++; end
    if (g == 50) tmo("rst_mid_ar");
    step();
    mosi.arvalid = 1'b0;
    mosi.rready  = 1'b1;
    cnt = 0;
    g   = 0;
    while (g < 100) begin
      if (miso.rvalid) begin
        if (cnt == 2) break;
        cnt++;
      end
      step();
      g++;
    end
    if (g == 100) tmo("rst_mid_beats");
    chk("rst_mid_beat2_data", 64'(miso.rdata), 64'd3);
    arst        = 1'b1;
    mosi.rready = 1'b0;
    step();
    chk("rst_mid_rvalid", 64'(miso.rvalid), 64'd0);
    chk("rst_mid_arready", 64'(miso.arready), 64'd0);
    chk("rst_mid_rlast", 64'(miso.rlast), 64'd0);
    arst = 1'b0;
    step();
    chk("rst_after_arready", 64'(miso.arready), 64'd1);
    chk("rst_after_rvalid", 64'(miso.rvalid), 64'd0);
    rexp[0] = 32'h9922BE44;
    axi_read("post_rst", 32'h10, 8'd21, 8'd0, 2'b01, 1'b0, 2'b00);

    // one word past the end: decode error, or aliases word 0
    wbuf[0] = 32'hCAFEF00D;
    axi_write("oob_wr", 32'h40, 8'd13, 8'd0, 2'b01, 4'hF, 1'b0, DEC ? 2'b11 : 2'b00);
    rexp[0] = DEC ? 32'd1 : 32'hCAFEF00D;
    axi_read("word0_rd", 32'h0, 8'd14, 8'd0, 2'b01, 1'b0, 2'b00);
    rexp[0] = DEC ? 32'd0 : 32'hCAFEF00D;
    axi_read("oob_rd", 32'h40, 8'd15, 8'd0, 2'b01, 1'b0, DEC ? 2'b11 : 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
